// File: rtl/fft_agu_pkg.sv
// fft_consts: shared state type and default sizing for the FFT address generator.
// Imported by fft_agu.
package fft_consts;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } agu_state_t;

  localparam int DEF_N_POINTS = 64;
  localparam int DEF_MEM_LAT  = 1;
  localparam int DEF_BFU_LAT  = 4;

endpackage

// File: rtl/agu_delay_line.sv
// agu_delay_line: DEPTH-stage shift register with enable and async clear.
// Carries write-back valid/addresses across the memory + butterfly latency.
module agu_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fft_agu.sv
// fft_agu: in-place radix-2 DIT FFT address generator with drain-aware stage sequencing.
// Defining FFT_AGU_CYCLE_CNT_EN adds a 32-bit busy-cycle counter output (cycle_cnt).
module fft_agu
  import fft_consts::*;
#(
  parameter int N_POINTS = DEF_N_POINTS,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int BFU_LAT  = DEF_BFU_LAT
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                stall,
  output logic                                rd_en,
  output logic [$clog2(N_POINTS)-1:0]         rd_addr_a,
  output logic [$clog2(N_POINTS)-1:0]         rd_addr_b,
  output logic [$clog2(N_POINTS)-2:0]         tw_addr,
  output logic                                bfu_en,
  output logic                                wr_en,
  output logic [$clog2(N_POINTS)-1:0]         wr_addr_a,
  output logic [$clog2(N_POINTS)-1:0]         wr_addr_b,
  output logic [$clog2($clog2(N_POINTS)):0]   stage_idx,
  output logic                                busy,
`ifdef FFT_AGU_CYCLE_CNT_EN
  output logic [31:0]                         cycle_cnt,
`endif
  output logic                                done
);

  localparam int LOG2N    = $clog2(N_POINTS);
  localparam int PIPE_LAT = MEM_LAT + BFU_LAT;
  localparam int AW       = LOG2N;
  localparam int KW       = LOG2N - 1;
  localparam int SW       = $clog2(LOG2N) + 1;
  localparam int DW       = $clog2(PIPE_LAT + 1);

  localparam logic [KW-1:0] K_LAST = KW'(N_POINTS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  agu_state_t state, state_nx;

  logic [KW-1:0] k;
  logic [SW-1:0] stage;
  logic [DW-1:0] dcnt;
  logic          adv;

  logic [AW-1:0] k_ext, half, j, base;
  logic [AW-1:0] addr_a, addr_b;
  logic [KW-1:0] tw;
  logic [AW-1:0] a_q, b_q;
  logic [KW-1:0] tw_q;

  logic          d_valid;
  logic [AW-1:0] d_a, d_b;

  assign adv = ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else if (adv) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: if (k == K_LAST) state_nx = S_DRAIN;
      S_DRAIN: begin
        if (dcnt == D_LAST)
          state_nx = (stage == S_LAST) ? S_DONE : S_ISSUE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en  = (state == S_ISSUE) & adv;
    bfu_en = adv & rst_n;
    busy   = (state != S_IDLE);
    done   = (state == S_DONE) & adv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      stage <= '0;
      dcnt  <= '0;
    end else if (adv) begin
      unique case (state)
        S_IDLE: begin
          k     <= '0;
          stage <= '0;
          dcnt  <= '0;
        end
        S_ISSUE: begin
          k    <= (k == K_LAST) ? '0 : k + KW'(1);
          dcnt <= '0;
        end
        S_DRAIN: begin
          if (dcnt == D_LAST) begin
            dcnt <= '0;
            if (stage != S_LAST) stage <= stage + SW'(1);
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        S_DONE:  stage <= '0;
        default: stage <= '0;
      endcase
    end
  end

  // butterfly k of stage s: group k>>s spans 2*half words, j is the offset inside it
  always_comb begin
    k_ext  = AW'(k);
    half   = AW'(1) << stage;
    j      = k_ext & (half - AW'(1));
    base   = (k_ext >> stage) << (stage + SW'(1));
    addr_a = base + j;
    addr_b = addr_a + half;
    tw     = KW'(j) << (S_LAST - stage);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      tw_q <= '0;
    end else if (rd_en) begin
      a_q  <= addr_a;
      b_q  <= addr_b;
      tw_q <= tw;
    end
  end

  assign rd_addr_a = rd_en ? addr_a : a_q;
  assign rd_addr_b = rd_en ? addr_b : b_q;
  assign tw_addr   = rd_en ? tw     : tw_q;
  assign stage_idx = stage;

  // idle slots carry the held addresses so write addresses stay put between writes
  agu_delay_line #(
    .DEPTH(PIPE_LAT),
    .WIDTH(1 + 2 * AW)
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (adv),
    .din  ({rd_en, rd_addr_a, rd_addr_b}),
    .dout ({d_valid, d_a, d_b})
  );

  assign wr_en     = d_valid & adv;
  assign wr_addr_a = d_a;
  assign wr_addr_b = d_b;

`ifdef FFT_AGU_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle_cnt <= '0;
    else if (state == S_IDLE && start && adv) cycle_cnt <= '0;
    else if (busy) cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fft_agu.sv
// tb_fft_agu: scoreboard bench for fft_agu at N_POINTS=8, MEM_LAT=1, BFU_LAT=4.
// Directed runs (plain, stall, ignored start, mid-run reset) then random stall/start traffic.
`timescale 1ns/1ps
module tb_fft_agu;

  localparam int N      = 8;
  localparam int ML     = 1;
  localparam int BL     = 4;
  localparam int LOG2N  = 3;
  localparam int PL     = ML + BL;
  localparam int T_DONE = 1 + LOG2N * (N / 2 + PL);

  typedef struct {
    int a;
    int b;
    int tw;
    int s;
  } rd_t;

  typedef struct {
    int a;
    int b;
    int t;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n, start, stall;
  logic       rd_en, bfu_en, wr_en, busy, done;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr;
  logic [2:0] stage_idx;
`ifdef FFT_AGU_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  fft_agu #(
    .N_POINTS(N),
    .MEM_LAT (ML),
    .BFU_LAT (BL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stall    (stall),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_addr  (tw_addr),
    .bfu_en   (bfu_en),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b),
    .stage_idx(stage_idx),
    .busy     (busy),
`ifdef FFT_AGU_CYCLE_CNT_EN
    .cycle_cnt(cycle_cnt),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  rd_t rd_q[$];
  wr_t wr_q[$];

  // reference: textbook DIT loop nest, groups outer, offsets inner
  task automatic load_model();
    for (int s = 0; s < LOG2N; s++) begin
      int half;
      half = 1 << s;
      for (int g = 0; g < N; g += 2 * half)
        for (int j = 0; j < half; j++)
          rd_q.push_back('{a: g + j, b: g + j + half,
                           tw: j * (N / (2 * half)), s: s});
    end
  endtask

  int          cyc = 0;
  int          adv_cnt = 0;
  bit          m_busy = 0;
  int          done_at = 0;
  int          wr_seen = 0;
  int          acc_cyc = 0;
  int          last_done_cyc = 0;
  bit          p_stall = 0;
  logic [21:0] outs_now, outs_prev;

  always @(negedge clk) begin
    bit  adv, acc, exp_done;
    rd_t e;
    wr_t w;
    outs_now = {rd_en, rd_addr_a, rd_addr_b, tw_addr, bfu_en, wr_en,
                wr_addr_a, wr_addr_b, stage_idx, busy, done};
    if (!rst_n) begin
      check("reset_outputs", 32'(outs_now), 32'd0);
      rd_q.delete();
      wr_q.delete();
      m_busy  = 0;
      p_stall = 0;
    end else begin
      adv      = !stall;
      acc      = !m_busy && start && adv;
      exp_done = m_busy && adv && (adv_cnt == done_at);
      check("bfu_en", 32'(bfu_en), 32'(adv));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(exp_done));
      if (stall) check("stall_rd_wr", 32'({rd_en, wr_en}), 32'd0);
      if (stall && p_stall) check("frozen", 32'(outs_now), 32'(outs_prev));
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got read %0d/%0d, expected none",
                   rd_addr_a, rd_addr_b);
        end else begin
          e = rd_q.pop_front();
          check("rd_addr_a", 32'(rd_addr_a), e.a);
          check("rd_addr_b", 32'(rd_addr_b), e.b);
          check("tw_addr", 32'(tw_addr), e.tw);
          check("stage_idx", 32'(stage_idx), e.s);
          check("rd_after_prev_wr", 32'(wr_seen >= e.s * (N / 2)), 32'd1);
          wr_q.push_back('{a: e.a, b: e.b, t: adv_cnt + PL});
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_stray: got write %0d/%0d, expected none",
                   wr_addr_a, wr_addr_b);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr_a", 32'(wr_addr_a), w.a);
          check("wr_addr_b", 32'(wr_addr_b), w.b);
          check("wr_latency", adv_cnt, w.t);
          wr_seen++;
        end
      end
      if (exp_done) begin
        m_busy        = 0;
        last_done_cyc = cyc;
`ifdef FFT_AGU_CYCLE_CNT_EN
        check("cycle_cnt", cycle_cnt, 32'(cyc - acc_cyc - 1));
`endif
      end
      if (acc) begin
        load_model();
        m_busy  = 1;
        done_at = adv_cnt + T_DONE;
        wr_seen = 0;
        acc_cyc = cyc;
      end
      if (adv) adv_cnt++;
      p_stall = stall;
    end
    outs_prev = outs_now;
    cyc++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    @(negedge clk);
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: busy after %0d cycles, expected idle", nm, lim);
    end
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // plain run: 28-cycle start-to-done latency
    pulse_start();
    wait_idle("plain", 200);
    check("plain_latency", 32'(last_done_cyc - acc_cyc), 32'd28);

    // three stalled cycles mid-ISSUE push done out by three
    pulse_start();
    tick(2);
    stall = 1'b1;
    tick(3);
    stall = 1'b0;
    wait_idle("stall", 200);
    check("stall_latency", 32'(last_done_cyc - acc_cyc), 32'd31);

    // start during stage 1 is ignored
    pulse_start();
    tick(11);
    pulse_start();
    wait_idle("restart", 200);
    check("ignored_start_latency", 32'(last_done_cyc - acc_cyc), 32'd28);

    // reset during stage-1 drain, then a clean run
    pulse_start();
    n = 0;
    @(negedge clk);
    while (!(busy && stage_idx == 3'd1 && !rd_en) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_s1_drain", 32'(stage_idx), 32'd1);
    tick();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    pulse_start();
    wait_idle("post_reset", 200);
    check("post_reset_latency", 32'(last_done_cyc - acc_cyc), 32'd28);

    // random stall and start traffic
    for (int i = 0; i < 1500; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      start = ($urandom_range(0, 9) == 0);
      tick();
    end
    stall = 1'b0;
    start = 1'b0;
    wait_idle("random", 400);
    tick(2);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
